pixel_fetch_cache: RTL and testbench

- Responder side of the pixel request interface used by the edge searchers.
- A searcher drives a pixel coordinate (x, y). This block returns the binary pixel value with a ready flag.
- On a miss it fetches the packed byte holding that pixel from image_memory, which stores 8 pixels per byte and 80 bytes per row.
- A small direct-mapped byte cache absorbs the raster-order locality of the searches.

---
 rtl/pixel_pkg.sv | 22 ++
 rtl/pixel_fetch_cache_line_store.sv | 47 ++++
 rtl/pixel_fetch_cache.sv | 112 +++++++++++
 tb/tb_pixel_fetch_cache.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared constants, byte-address helper and fetch FSM states for the pixel fetch cache.
package pixel_pkg;

  localparam int IMG_W         = 640;
  localparam int IMG_H         = 480;
  localparam int BYTES_PER_ROW = 80;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FILL
  } fetch_state_t;

  // y*80 + x/8 built from shifts so no multiplier is inferred
  function automatic logic [15:0] pixel_byte_addr(input logic [9:0] x, input logic [9:0] y);
    logic [15:0] yw;
    yw = {6'b0, y};
    return (yw << 6) + (yw << 4) + {9'b0, x[9:3]};
  endfunction

endpackage

// File: rtl/pixel_fetch_cache_line_store.sv
// Direct-mapped byte line store: tag/data arrays with one write port, a combinational
// read port and a single-cycle flush of every valid bit.
module pixel_line_store #(
  parameter int LINES = 4,
  parameter int IDX_W = 2,
  parameter int TAG_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [7:0]       rd_data
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [7:0]       data_mem [LINES];

  // flush beats a simultaneous write so a dropped fill never becomes visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/pixel_fetch_cache.sv
// Pixel request responder: zero-latency hits from a direct-mapped byte cache, misses
// fetched from packed image memory (8 pixels per byte) through a small FSM.
module pixel_fetch_cache
  import pixel_pkg::*;
#(
  parameter int IMG_W       = pixel_pkg::IMG_W,
  parameter int IMG_H       = pixel_pkg::IMG_H,
  parameter int LINES       = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        pixel,
  output logic        ready,
  input  logic        invalidate,
  output logic [15:0] rdaddress,
  input  logic [7:0]  rdata
);

  localparam int IDX_LOG = $clog2(LINES);
  localparam int IDX_W   = (IDX_LOG > 0) ? IDX_LOG : 1;
  localparam int TAG_W   = 16 - IDX_LOG;
  localparam logic [9:0] X_LIM = 10'(IMG_W);
  localparam logic [9:0] Y_LIM = 10'(IMG_H);

  fetch_state_t state, state_nxt;
  logic [15:0] addr, miss_addr;
  logic [1:0]  lat_cnt;
  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag;
  logic        out_of_frame, hit, load_miss, fill_we;
  logic        line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [7:0]  line_data;

  assign addr         = pixel_byte_addr(x, y);
  assign idx          = (LINES == 1) ? '0 : addr[IDX_W-1:0];
  assign tag          = TAG_W'(addr >> IDX_LOG);
  assign fill_idx     = (LINES == 1) ? '0 : miss_addr[IDX_W-1:0];
  assign fill_tag     = TAG_W'(miss_addr >> IDX_LOG);
  assign out_of_frame = (x >= X_LIM) || (y >= Y_LIM);

  pixel_line_store #(
    .LINES(LINES),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_line_store (
    .clk     (clk),
    .reset   (reset),
    .flush   (invalidate),
    .we      (fill_we),
    .wr_idx  (fill_idx),
    .wr_tag  (fill_tag),
    .wr_data (rdata),
    .rd_idx  (idx),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data)
  );

  assign hit   = line_valid && (line_tag == tag);
  assign ready = out_of_frame || hit;
  assign pixel = !out_of_frame && hit && line_data[x[2:0]];

  always_comb begin
    state_nxt = state;
    load_miss = 1'b0;
    fill_we   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!invalidate && !out_of_frame && !hit) begin
          load_miss = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = invalidate ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (invalidate)          state_nxt = S_IDLE;
        else if (lat_cnt == 2'd0) state_nxt = S_FILL;
      end
      S_FILL: begin
        fill_we   = !invalidate;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // rdaddress only moves when a new miss is accepted, so it is stable for the whole fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      miss_addr <= '0;
      rdaddress <= '0;
      lat_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load_miss) begin
        miss_addr <= addr;
        rdaddress <= addr;
      end
      if (state == S_ISSUE) begin
        lat_cnt <= 2'(MEM_LATENCY - 1);
      end else if (state == S_WAIT && lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_fetch_cache.sv
// Directed bench for pixel_fetch_cache with a one-cycle-latency image memory model.
module tb_pixel_fetch_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        pixel;
  logic        ready;
  logic        invalidate = 1'b0;
  logic [15:0] rdaddress;
  logic [7:0]  rdata = '0;
  logic [7:0]  mem [0:38399];
  int n_checks = 0;
  int n_fail   = 0;

  pixel_fetch_cache #(
    .IMG_W(640),
    .IMG_H(480),
    .LINES(4),
    .MEM_LATENCY(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .pixel     (pixel),
    .ready     (ready),
    .invalidate(invalidate),
    .rdaddress (rdaddress),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[rdaddress];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    x = 10'd0; y = 10'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_checks++;
    if (pixel !== 1'b0) begin n_fail++; $display("FAIL reset_pixel: got %b want 0", pixel); end
    n_checks++;
    if (rdaddress !== 16'd0) begin n_fail++; $display("FAIL reset_rdaddress: got %0d want 0", rdaddress); end
    x = 10'd640;
    #1;
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_oof_ready: got %b want 1", ready); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_miss_fill();
    int cyc;
    x = 10'd7; y = 10'd2;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL miss_ready_low: got %b want 0", ready); end
    wait_ready(cyc);
    n_checks++;
    if (cyc != 4) begin n_fail++; $display("FAIL miss_latency: got %0d want 4", cyc); end
    n_checks++;
    if (pixel !== 1'b1) begin n_fail++; $display("FAIL miss_pixel: got %b want 1", pixel); end
    n_checks++;
    if (rdaddress !== 16'd160) begin n_fail++; $display("FAIL miss_rdaddress: got %0d want 160", rdaddress); end
  endtask

  task automatic test_hit();
    int cyc;
    x = 10'd6; y = 10'd2;
    #1;
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL hit_ready: got %b want 1", ready); end
    n_checks++;
    if (pixel !== 1'b0) begin n_fail++; $display("FAIL hit_pixel: got %b want 0", pixel); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (rdaddress !== 16'd160 || ready !== 1'b1) begin
      n_fail++; $display("FAIL hit_stable: got addr %0d ready %b want 160 1", rdaddress, ready);
    end
    x = 10'd9; y = 10'd4;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL miss321_ready_low: got %b want 0", ready); end
    wait_ready(cyc);
    n_checks++;
    if (cyc != 4) begin n_fail++; $display("FAIL miss321_latency: got %0d want 4", cyc); end
    n_checks++;
    if (pixel !== 1'b1 || rdaddress !== 16'd321) begin
      n_fail++; $display("FAIL miss321_result: got pixel %b addr %0d want 1 321", pixel, rdaddress);
    end
  endtask

  task automatic test_evict();
    int cyc;
    x = 10'd32; y = 10'd2;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL evict_miss164: got %b want 0", ready); end
    wait_ready(cyc);
    n_checks++;
    if (cyc != 4 || pixel !== 1'b1 || rdaddress !== 16'd164) begin
      n_fail++; $display("FAIL evict_fill164: got cyc %0d pixel %b addr %0d want 4 1 164", cyc, pixel, rdaddress);
    end
    x = 10'd7; y = 10'd2;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL evict_remiss160: got %b want 0", ready); end
    wait_ready(cyc);
    n_checks++;
    if (cyc != 4 || pixel !== 1'b1 || rdaddress !== 16'd160) begin
      n_fail++; $display("FAIL evict_refill160: got cyc %0d pixel %b addr %0d want 4 1 160", cyc, pixel, rdaddress);
    end
  endtask

  task automatic test_out_of_frame();
    int cyc;
    x = 10'd640; y = 10'd0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || pixel !== 1'b0) begin
      n_fail++; $display("FAIL oof_x: got ready %b pixel %b want 1 0", ready, pixel);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (rdaddress !== 16'd160) begin n_fail++; $display("FAIL oof_x_nofetch: got %0d want 160", rdaddress); end
    x = 10'd0; y = 10'd480;
    #1;
    n_checks++;
    if (ready !== 1'b1 || pixel !== 1'b0) begin
      n_fail++; $display("FAIL oof_y: got ready %b pixel %b want 1 0", ready, pixel);
    end
    repeat (3) @(negedge clk);
    x = 10'd7; y = 10'd2;
    #1;
    n_checks++;
    if (ready !== 1'b1 || pixel !== 1'b1) begin
      n_fail++; $display("FAIL oof_cache_kept: got ready %b pixel %b want 1 1", ready, pixel);
    end
    @(negedge clk);
    x = 10'd639; y = 10'd479;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL corner_miss: got %b want 0", ready); end
    wait_ready(cyc);
    n_checks++;
    if (cyc != 4 || pixel !== 1'b1 || rdaddress !== 16'd38399) begin
      n_fail++; $display("FAIL corner_fill: got cyc %0d pixel %b addr %0d want 4 1 38399", cyc, pixel, rdaddress);
    end
  endtask

  task automatic test_invalidate();
    int cyc;
    x = 10'd3; y = 10'd3;
    @(negedge clk);
    @(negedge clk);
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL inv_dropped: got %b want 0", ready); end
    wait_ready(cyc);
    n_checks++;
    if (cyc != 4) begin n_fail++; $display("FAIL inv_refetch_latency: got %0d want 4", cyc); end
    n_checks++;
    if (pixel !== 1'b1 || rdaddress !== 16'd240) begin
      n_fail++; $display("FAIL inv_refetch_result: got pixel %b addr %0d want 1 240", pixel, rdaddress);
    end
    x = 10'd639; y = 10'd479;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL inv_flushed: got %b want 0", ready); end
    wait_ready(cyc);
    n_checks++;
    if (cyc != 4) begin n_fail++; $display("FAIL inv_corner_refill: got %0d want 4", cyc); end
  endtask

  task automatic test_reset_mid_fetch();
    int cyc;
    x = 10'd9; y = 10'd4;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (ready !== 1'b0 || rdaddress !== 16'd0) begin
      n_fail++; $display("FAIL rst_abort: got ready %b addr %0d want 0 0", ready, rdaddress);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_nofill: got %b want 0", ready); end
    wait_ready(cyc);
    n_checks++;
    if (cyc != 4 || pixel !== 1'b1 || rdaddress !== 16'd321) begin
      n_fail++; $display("FAIL rst_refetch: got cyc %0d pixel %b addr %0d want 4 1 321", cyc, pixel, rdaddress);
    end
  endtask

  initial begin
    for (int i = 0; i < 38400; i++) mem[i] = 8'h00;
    mem[160]   = 8'b1000_0000;
    mem[164]   = 8'b0000_0001;
    mem[240]   = 8'b0000_1000;
    mem[321]   = 8'b0000_0010;
    mem[400]   = 8'b0010_0000;
    mem[38399] = 8'b1000_0000;

    test_reset();
    test_miss_fill();
    test_hit();
    test_evict();
    test_out_of_frame();
    test_invalidate();
    test_reset_mid_fetch();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
